// File: rtl/bsg_reduce_accum_pkg.sv
// Shared types and helpers for the packet reduction stage: reduction op select,
// control states, and the per-op identity/fold functions.
package bsg_reduce_pkg;

  typedef enum logic [1:0] {
    e_reduce_and,
    e_reduce_or,
    e_reduce_xor
  } bsg_reduce_op_e;

  typedef enum logic {
    e_accum,
    e_full
  } bsg_reduce_accum_state_e;

  function automatic logic reduce_identity(bsg_reduce_op_e op);
    return (op == e_reduce_and);
  endfunction

  function automatic logic reduce_combine(bsg_reduce_op_e op, logic a, logic b);
    logic r;
    case (op)
      e_reduce_and: r = a & b;
      e_reduce_or:  r = a | b;
      default:      r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bsg_reduce_accum_if.sv
// Beat input (valid/ready) and packet result output (valid/yumi) of the reduction stage.
interface bsg_reduce_accum_if #(
  parameter int width_p     = 32,
  parameter int max_beats_p = 16
);
  localparam int count_width_lp = $clog2(max_beats_p + 1);

  logic                      v_i;
  logic [width_p-1:0]        data_i;
  logic                      last_i;
  logic                      ready_o;
  logic                      v_o;
  logic                      data_o;
  logic [count_width_lp-1:0] count_o;
  logic                      ovf_o;
  logic                      yumi_i;

  modport slave (
    input  v_i, data_i, last_i, yumi_i,
    output ready_o, v_o, data_o, count_o, ovf_o
  );

  modport master (
    output v_i, data_i, last_i, yumi_i,
    input  ready_o, v_o, data_o, count_o, ovf_o
  );
endinterface

// File: rtl/bsg_reduce_accum_reduce.sv
// Single-vector bit reduction; exactly one of xor_p/and_p/or_p is expected to be set.
module bsg_reduce #(
  parameter int width_p = 32,
  parameter bit xor_p   = 1'b0,
  parameter bit and_p   = 1'b0,
  parameter bit or_p    = 1'b0
) (
  input  logic [width_p-1:0] i,
  output logic               o
);

  if (xor_p) begin : g_xor
    assign o = ^i;
  end else if (and_p) begin : g_and
    assign o = &i;
  end else begin : g_or
    assign o = |i;
  end

endmodule

// File: rtl/bsg_reduce_accum.sv
// Folds a per-beat reduction bit across a packet and holds the packet result,
// a saturating beat count and an overflow flag until the consumer takes it.
module bsg_reduce_accum
  import bsg_reduce_pkg::*;
#(
  parameter int             width_p     = 32,
  parameter bsg_reduce_op_e op_p        = e_reduce_and,
  parameter int             max_beats_p = 16
) (
  input logic                clk_i,
  input logic                reset_i,
  bsg_reduce_accum_if.slave  bus
);

  localparam int                  count_width_lp = $clog2(max_beats_p + 1);
  localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_beats_p);
  localparam logic                acc_identity_lp = reduce_identity(op_p);

  bsg_reduce_accum_state_e   state_reg, state_next;
  logic                      acc_reg, acc_next;
  logic [count_width_lp-1:0] cnt_reg, cnt_next;
  logic                      ovf_reg, ovf_next;
  logic                      res_data_reg, res_data_next;
  logic [count_width_lp-1:0] res_count_reg, res_count_next;
  logic                      res_ovf_reg, res_ovf_next;

  logic                      beat_bit;
  logic                      acc_fold;
  logic [count_width_lp-1:0] cnt_inc;
  logic                      ovf_fold;

  bsg_reduce #(
    .width_p (width_p),
    .xor_p   (op_p == e_reduce_xor),
    .and_p   (op_p == e_reduce_and),
    .or_p    (op_p == e_reduce_or)
  ) reduce (
    .i (bus.data_i),
    .o (beat_bit)
  );

  // Count saturates; a beat arriving while already at max marks the packet as overflowed.
  assign acc_fold = reduce_combine(op_p, acc_reg, beat_bit);
  assign cnt_inc  = (cnt_reg == max_count_lp) ? max_count_lp : cnt_reg + count_width_lp'(1);
  assign ovf_fold = ovf_reg | (cnt_reg == max_count_lp);

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    ovf_next       = ovf_reg;
    res_data_next  = res_data_reg;
    res_count_next = res_count_reg;
    res_ovf_next   = res_ovf_reg;
    case (state_reg)
      e_accum: begin
        if (bus.v_i) begin
          if (bus.last_i) begin
            res_data_next  = acc_fold;
            res_count_next = cnt_inc;
            res_ovf_next   = ovf_fold;
            acc_next       = acc_identity_lp;
            cnt_next       = '0;
            ovf_next       = 1'b0;
            state_next     = e_full;
          end else begin
            acc_next = acc_fold;
            cnt_next = cnt_inc;
            ovf_next = ovf_fold;
          end
        end
      end
      e_full: begin
        if (bus.yumi_i) begin
          state_next = e_accum;
        end
      end
      default: state_next = e_accum;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= e_accum;
      acc_reg       <= acc_identity_lp;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      res_data_reg  <= 1'b0;
      res_count_reg <= '0;
      res_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      res_data_reg  <= res_data_next;
      res_count_reg <= res_count_next;
      res_ovf_reg   <= res_ovf_next;
    end
  end

  // Result fields read as zero whenever no result is being offered.
  assign bus.v_o     = (state_reg == e_full);
  assign bus.ready_o = (state_reg == e_accum);
  assign bus.data_o  = bus.v_o & res_data_reg;
  assign bus.count_o = bus.v_o ? res_count_reg : '0;
  assign bus.ovf_o   = bus.v_o & res_ovf_reg;

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.yumi_i |-> bus.v_o);

endmodule
